count_tick_ctrl: RTL and testbench
==================================

# count_tick_ctrl

Control stage directly upstream of the two-digit seven-segment counter. It debounces the raw run/pause and clear push-buttons and keeps a run/stop state. It divides the 50 MHz base clock into a one-cycle `enable` pulse for the counter, and emits a one-cycle `clear` pulse that drives the counter's clear/reset input through top-level glue.

## Interface
- `TICK_DIV`, 50_000_000: base-clock cycles per `enable` pulse while running. Must be ≥ 2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive cycles a synchronized button level must hold before it is accepted (20 ms at 50 MHz). Must be ≥ 2.

- `clk`  in  1  base clock, 50 MHz, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `btn_run`  in  1  raw run/pause button, asynchronous, active-high.
- `btn_clr`  in  1  raw clear button, asynchronous, active-high.
- `enable`  out  1  one-cycle count pulse to the counter's `enable`.
- `clear`  out  1  one-cycle pulse on accepted clear press.
- `running`  out  1  level; 1 in RUN state.

## Operation
- Each button passes through a 2-flop synchronizer, then its own debouncer.
- Debouncer holds `db` and counter `dc`:
  - `sync == db`: `dc <= 0`.
  - Otherwise `dc` increments.
  - When `dc == DEBOUNCE_CYCLES-1` with `sync != db`: `db <= sync` and `dc <= 0`.
  - Any bounce back to `db` restarts the count.
- Press event: `db` registered 0 then current 1 (rising edge of `db`). Release is ignored.
- State machine, two states:
  - STOP: run press → RUN.
  - RUN: run press → STOP.
  - Clear press in either state → STOP.
  - Clear press and run press in the same cycle: clear wins, next state STOP.
- Prescaler `pc`, `$clog2(TICK_DIV)` bits:
  - In RUN: increments; at `TICK_DIV-1` it wraps to 0 and `enable` = 1 for that one cycle.
  - In STOP: `pc` holds its value, so pause/resume keeps the partial interval.
  - Clear press: `pc <= 0`.
- `enable` is never asserted in STOP, or in the cycle `clear` is asserted.
- `clear` = 1 for exactly one cycle per accepted clear press, regardless of state.
- Holding a button asserted produces only one event.

## Timing
- All outputs are registered.
- Reset values: `enable` = 0, `clear` = 0, `running` = 0 (STOP); `pc`, `dc` = 0; `db` = 0; synchronizers = 0.
- Reset is asynchronous and takes effect mid-count or mid-debounce, discarding partial progress. Release is sampled on the next rising `clk`.
- Press latency: raw rise → `db` rise = 2 (sync) + `DEBOUNCE_CYCLES` cycles. `running`/`clear` update one cycle later.
- First `enable` after entering RUN from `pc` = 0: asserted in the `TICK_DIV`-th cycle in RUN. Steady-state period is exactly `TICK_DIV` cycles.
- RUN → STOP on the same edge that `pc` would wrap: that `enable` is suppressed and `pc` keeps `TICK_DIV-1`. The next RUN entry fires `enable` in its first cycle.

## Configuration
- `COUNT_TICK_AUTO_START_EN` defined:
  - Reset value of the state is RUN; `running` resets to 1.
  - The counter advances from power-up without a button press.
  - All other behaviour is unchanged, including run press → STOP.
- Not defined: reset to STOP as specified above.

## Test plan
Run with `TICK_DIV=5`, `DEBOUNCE_CYCLES=4`, 20 ns clock.
- Reset low 100 ns, then high, buttons idle → `running`=0, `enable`=0, `clear`=0 for 50 cycles. With the macro: `running`=1 and `enable` every 5 cycles.
- `btn_run` high 10 cycles → `running` rises 7 cycles after raw rise. `enable` pulses every 5 cycles, the first 5 cycles after `running` rises. Second press → `running`=0 and pulses stop.
- `btn_run` bouncing 1,0,1,0 per cycle for 12 cycles then low → no state change, `running` stays 0.
- RUN, stop after 3 RUN cycles (`pc`=3), press again → first `enable` 2 cycles into the new RUN.
- `btn_clr` and `btn_run` rise together in RUN → `clear` one-cycle pulse, `running`=0, `pc`=0, no `enable` in that cycle.
- Assert `reset` low for one cycle mid-RUN between ticks → all outputs 0 asynchronously. After release, no `enable` until a new run press.

Source files
------------

// File: rtl/count_tick_ctrl.sv
// count_tick_ctrl: run/pause + clear control ahead of the two-digit counter.
// Debounces both push-buttons, keeps a RUN/STOP state, divides the base clock
// into a one-cycle enable pulse and emits a one-cycle clear pulse.
// Optional macro: COUNT_TICK_AUTO_START_EN -- state resets to RUN instead of STOP.

// Per-button lane: 2-flop synchronizer, level debouncer, rising-edge press detect.
module count_tick_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_press
);
  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]     r_sync;
  logic           r_db;
  logic           r_db_q;
  logic [DCW-1:0] r_dc;

  // Synchronize, then accept a new level only after it held DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_db   <= 1'b0;
      r_db_q <= 1'b0;
      r_dc   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_db_q <= r_db;
      if (r_sync[1] == r_db) begin
        r_dc <= '0;
      end else if (r_dc == DCW'(DEBOUNCE_CYCLES - 1)) begin
        r_db <= r_sync[1];
        r_dc <= '0;
      end else begin
        r_dc <= r_dc + 1'b1;
      end
    end
  end

  // Press is the accepted rising edge only; releases are ignored.
  assign o_press = r_db & ~r_db_q;
endmodule

module count_tick_ctrl #(
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_clr,
  output logic enable,
  output logic clear,
  output logic running
);
  localparam int NUM_BTN = 2;
  localparam int BTN_RUN = 0;
  localparam int BTN_CLR = 1;
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

`ifdef COUNT_TICK_AUTO_START_EN
  localparam state_t ST_RESET = ST_RUN;
`else
  localparam state_t ST_RESET = ST_STOP;
`endif

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_press;
  logic               w_run_press;
  logic               w_clr_press;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_pc;
  logic               r_enable;
  logic               r_clear;

  assign w_btn_raw = {btn_clr, btn_run};

  count_tick_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db [NUM_BTN-1:0] (
    .clk    (clk),
    .rst_n  (reset),
    .i_raw  (w_btn_raw),
    .o_press(w_press)
  );

  assign w_run_press = w_press[BTN_RUN];
  assign w_clr_press = w_press[BTN_CLR];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RESET;
    else        r_state <= w_state_nxt;
  end

  // Next state: clear forces STOP and beats a simultaneous run press.
  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_press) begin
      w_state_nxt = ST_STOP;
    end else if (w_run_press) begin
      w_state_nxt = (r_state == ST_RUN) ? ST_STOP : ST_RUN;
    end
  end

  // Prescaler advances for every cycle spent in RUN, so a pause keeps the
  // partial interval; a stop on the wrap edge leaves pc at TICK_DIV-1 and the
  // suppressed tick fires in the first cycle of the next RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= '0;
      r_enable <= 1'b0;
      r_clear  <= 1'b0;
    end else begin
      r_clear  <= w_clr_press;
      r_enable <= 1'b0;
      if (w_clr_press) begin
        r_pc <= '0;
      end else if (w_state_nxt == ST_RUN) begin
        if (r_pc == PW'(TICK_DIV - 1)) begin
          r_pc     <= '0;
          r_enable <= 1'b1;
        end else begin
          r_pc <= r_pc + 1'b1;
        end
      end
    end
  end

  assign enable  = r_enable;
  assign clear   = r_clear;
  assign running = (r_state == ST_RUN);
endmodule

// File: tb/tb_count_tick_ctrl.sv
// tb_count_tick_ctrl: directed + random button stimulus against a cycle model
// built from button-level rules (history windows and cumulative RUN time).
module tb_count_tick_ctrl;
  localparam int TD = 5;
  localparam int DC = 4;
`ifdef COUNT_TICK_AUTO_START_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn_run;
  logic btn_clr;
  logic enable;
  logic clear;
  logic running;

  int n_vec = 0;
  int n_bad = 0;
  string phase = "init";

  // model state
  bit       hist [2][DC+2];
  bit [1:0] m_db;
  bit [1:0] m_dbq;
  bit       m_state;
  int       m_runcnt;
  bit       e_enable, e_clear, e_running;

  count_tick_ctrl #(
    .TICK_DIV(TD),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_run(btn_run),
    .btn_clr(btn_clr),
    .enable (enable),
    .clear  (clear),
    .running(running)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t {en,clr,run} got %b want %b", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < DC + 2; k++) hist[b][k] = 1'b0;
    m_db = '0; m_dbq = '0;
    m_state = AUTO; m_runcnt = 0;
    e_enable = 1'b0; e_clear = 1'b0; e_running = AUTO;
  endtask

  // One rising edge: a button level is accepted once the last DC synchronized
  // samples (raw delayed by two edges) all disagree with the accepted level.
  // enable fires on every TD-th cumulative RUN cycle since reset/clear.
  task automatic model_step();
    bit [1:0] press;
    bit [1:0] raw;
    bit       flip;
    press = m_db & ~m_dbq;
    m_dbq = m_db;
    raw = {btn_clr, btn_run};
    for (int b = 0; b < 2; b++) begin
      for (int k = DC + 1; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = raw[b];
      flip = 1'b1;
      for (int k = 2; k < DC + 2; k++) if (hist[b][k] == m_db[b]) flip = 1'b0;
      if (flip) m_db[b] = ~m_db[b];
    end
    if (press[1]) begin
      m_state = 1'b0;
      m_runcnt = 0;
    end else if (press[0]) begin
      m_state = ~m_state;
    end
    e_clear = press[1];
    e_running = m_state;
    e_enable = 1'b0;
    if (!press[1] && m_state) begin
      m_runcnt++;
      e_enable = ((m_runcnt % TD) == 0);
    end
  endtask

  // Called at a negedge: drive buttons, model the next edge, check at the following negedge.
  task automatic tick(input bit r, input bit c);
    btn_run = r;
    btn_clr = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk(phase, {enable, clear, running}, {e_enable, e_clear, e_running});
  endtask

  // Mid-cycle asynchronous reset held across one rising edge.
  task automatic async_rst();
    #5;
    reset = 1'b0;
    #1;
    chk("async_rst", {enable, clear, running}, {2'b00, AUTO});
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("in_rst", {enable, clear, running}, {2'b00, AUTO});
    reset = 1'b1;
  endtask

  initial begin
    bit rr, rc;
    reset = 1'b0;
    btn_run = 1'b0;
    btn_clr = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("reset", {enable, clear, running}, {2'b00, AUTO});
    reset = 1'b1;

    phase = "idle";
    repeat (50) tick(0, 0);

    phase = "run_press";
    repeat (10) tick(1, 0);
    repeat (20) tick(0, 0);
    phase = "stop_press";
    repeat (10) tick(1, 0);
    repeat (15) tick(0, 0);

    phase = "bounce";
    for (int i = 0; i < 12; i++) tick((i % 2) == 0, 0);
    repeat (10) tick(0, 0);

    phase = "pause_resume";
    repeat (7) tick(1, 0);
    repeat (6) tick(0, 0);
    repeat (10) tick(1, 0);
    repeat (10) tick(0, 0);
    repeat (10) tick(1, 0);
    repeat (15) tick(0, 0);

    phase = "clr_and_run";
    repeat (8) tick(1, 1);
    repeat (15) tick(0, 0);

    phase = "rst_mid_run";
    repeat (10) tick(1, 0);
    repeat (9) tick(0, 0);
    async_rst();
    repeat (25) tick(0, 0);

    phase = "random";
    rr = 1'b0;
    rc = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5, 0) == 0) rr = ~rr;
      if ($urandom_range(11, 0) == 0) rc = ~rc;
      if ($urandom_range(299, 0) == 0) async_rst();
      tick(rr, rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
